// File: rtl/deserializador_fifo.sv
// deserializador_fifo
// Collects serial bits into WORD_W-bit words (MSB-first or LSB-first) and
// buffers completed words in a FIFO_DEPTH-entry FIFO popped by ack_in.
//
// Optional feature: define DESER_PARITY_EN to expect one even-parity bit after
// each word; words with bad parity are dropped and parity_err pulses.
//
// Ports:
//   clk_100KHz  system clock, rising edge
//   reset       asynchronous active-low reset
//   data_in     serial data bit
//   write_in    bit-valid strobe
//   ack_in      pop request (level-sensitive)
//   status_out  1 = ready to accept bits (FIFO not full), registered
//   data_out    FIFO head word, 0 while empty
//   data_ready  FIFO holds at least one word
//   fill_level  number of stored words
//   overflow    sticky, bit offered while status_out=0
//   parity_err  (DESER_PARITY_EN only) one-cycle pulse on a dropped word
module deserializador_fifo #(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                          clk_100KHz,
  input  logic                          reset,
  input  logic                          data_in,
  input  logic                          write_in,
  input  logic                          ack_in,
  output logic                          status_out,
  output logic [WORD_W-1:0]             data_out,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow
`ifdef DESER_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FillW = PtrW + 1;
`ifdef DESER_PARITY_EN
  localparam int unsigned FrameLen = WORD_W + 1;
`else
  localparam int unsigned FrameLen = WORD_W;
`endif
  localparam int unsigned CntW = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0]  LastBit   = CntW'(FrameLen - 1);
  localparam logic [FillW-1:0] DepthFill = FillW'(FIFO_DEPTH);

  logic [WORD_W-1:0] shreg_q, shreg_d, shifted, push_word;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0]  fill_q, fill_d;
  logic              status_q, overflow_q;
  logic              accept, frame_end, push, pop;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
`ifdef DESER_PARITY_EN
  logic              parity_err_q;
`endif

  always_comb begin
    accept    = write_in & status_q;
    frame_end = accept && (bit_cnt_q == LastBit);
    if (MSB_FIRST != 0) shifted = {shreg_q[WORD_W-2:0], data_in};
    else                shifted = {data_in, shreg_q[WORD_W-1:1]};
`ifdef DESER_PARITY_EN
    // Last accepted bit is the parity bit; the word is already complete in shreg_q.
    push      = frame_end & ~(^shreg_q ^ data_in);
    push_word = shreg_q;
`else
    push      = frame_end;
    push_word = shifted;
`endif
    pop = ack_in & (fill_q != '0);

    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (frame_end) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (accept) begin
      shreg_d   = shifted;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    fill_d = fill_q;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (!push && pop) fill_d = fill_q - 1'b1;
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      status_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      fill_q    <= fill_d;
      status_q  <= (fill_d < DepthFill);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (write_in && !status_q) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: data_out is gated while empty.
  always_ff @(posedge clk_100KHz) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) parity_err_q <= 1'b0;
    else        parity_err_q <= frame_end & ~push;
  end
  assign parity_err = parity_err_q;
`endif

  assign status_out = status_q;
  assign data_ready = (fill_q != '0);
  assign data_out   = data_ready ? mem[rd_ptr_q] : '0;
  assign fill_level = fill_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_deserializador_fifo.sv
module tb_deserializador_fifo;
  localparam int W = 8;
  localparam int D = 4;

  logic clk_100KHz = 1'b0;
  logic reset = 1'b0;
  logic data_in = 1'b0;
  logic write_in = 1'b0;
  logic ack_in = 1'b0;

  logic       st_m, dr_m, ov_m, st_l, dr_l, ov_l;
  logic [7:0] do_m, do_l;
  logic [2:0] fl_m, fl_l;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_100KHz = ~clk_100KHz;

  deserializador_fifo #(.WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1)) dut_msb (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .ack_in     (ack_in),
    .status_out (st_m),
    .data_out   (do_m),
    .data_ready (dr_m),
    .fill_level (fl_m),
    .overflow   (ov_m)
  );

  deserializador_fifo #(.WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(0)) dut_lsb (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .ack_in     (ack_in),
    .status_out (st_l),
    .data_out   (do_l),
    .data_ready (dr_l),
    .fill_level (fl_l),
    .overflow   (ov_l)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Model: words as queues, partial word as a list of received bits.
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  bit         bits[$];
  bit         m_ovf;

  task automatic model_clear();
    q_m.delete();
    q_l.delete();
    bits.delete();
    m_ovf = 1'b0;
  endtask

  initial begin : model_and_compare
    bit         room, do_pop;
    logic [7:0] wm, wl;
    forever begin
      @(posedge clk_100KHz);
      if (!reset) begin
        model_clear();
      end else begin
        room   = (q_m.size() < D);
        do_pop = ack_in && (q_m.size() > 0);
        if (write_in && !room) m_ovf = 1'b1;
        if (do_pop) begin
          void'(q_m.pop_front());
          void'(q_l.pop_front());
        end
        if (write_in && room) begin
          bits.push_back(data_in);
          if (bits.size() == W) begin
            for (int i = 0; i < W; i++) begin
              wm[W-1-i] = bits[i];
              wl[i]     = bits[i];
            end
            q_m.push_back(wm);
            q_l.push_back(wl);
            bits.delete();
          end
        end
      end
      @(negedge clk_100KHz);
      if (!reset) model_clear();
      check("m_ready",  dr_m, q_m.size() > 0);
      check("m_fill",   fl_m, q_m.size());
      check("m_status", st_m, q_m.size() < D);
      check("m_ovf",    ov_m, m_ovf);
      check("m_data",   do_m, (q_m.size() > 0) ? q_m[0] : 8'h00);
      check("l_ready",  dr_l, q_l.size() > 0);
      check("l_fill",   fl_l, q_l.size());
      check("l_status", st_l, q_l.size() < D);
      check("l_ovf",    ov_l, m_ovf);
      check("l_data",   do_l, (q_l.size() > 0) ? q_l[0] : 8'h00);
    end
  end

  task automatic step();
    @(posedge clk_100KHz);
    #1;
  endtask

  task automatic strobe(input bit b, input int idle);
    write_in = 1'b1;
    data_in  = b;
    step();
    write_in = 1'b0;
    repeat (idle) step();
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) strobe(w[i], 0);
  endtask

  logic [7:0] exp4 [4];
  logic [7:0] w22;

  initial begin : stimulus
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    w22 = 8'h22;

    // Reset state
    repeat (3) step();
    @(negedge clk_100KHz);
    check("rst_status", st_m, 1);
    check("rst_ready",  dr_m, 0);
    check("rst_data",   do_m, 8'h00);
    check("rst_fill",   fl_m, 0);
    check("rst_ovf",    ov_m, 0);
    step();
    reset = 1'b1;
    step();

    // 1,0,1,0,1,1,0,1 with idle cycles
    strobe(1, 1); strobe(0, 1); strobe(1, 1); strobe(0, 1);
    strobe(1, 1); strobe(1, 1); strobe(0, 1); strobe(1, 1);
    @(negedge clk_100KHz);
    check("t1_ready", dr_m, 1);
    check("t1_msb",   do_m, 8'hAD);
    check("t1_fill",  fl_m, 1);
    check("t1_lsb",   do_l, 8'hB5);
    step();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    @(negedge clk_100KHz);
    check("t1_pop_ready", dr_m, 0);
    check("t1_pop_fill",  fl_m, 0);
    // ack on empty FIFO is ignored
    step();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    @(negedge clk_100KHz);
    check("empty_ack_fill", fl_m, 0);

    // Fill to full, overflow, drain in order
    step();
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    @(negedge clk_100KHz);
    check("full_status", st_m, 0);
    check("full_fill",   fl_m, 4);
    step();
    strobe(1, 0); strobe(0, 0); strobe(1, 0);
    @(negedge clk_100KHz);
    check("ovf_flag", ov_m, 1);
    check("ovf_fill", fl_m, 4);
    step();
    ack_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100KHz);
      check("drain_order", do_m, exp4[i]);
      step();
    end
    ack_in = 1'b0;
    @(negedge clk_100KHz);
    check("drain_empty",  dr_m, 0);
    check("drain_status", st_m, 1);
    check("ovf_sticky",   ov_m, 1);

    // Simultaneous push and pop with one word stored
    step();
    send_word(8'h11);
    for (int i = 7; i >= 1; i--) strobe(w22[i], 0);
    write_in = 1'b1;
    data_in  = w22[0];
    ack_in   = 1'b1;
    step();
    write_in = 1'b0;
    ack_in   = 1'b0;
    @(negedge clk_100KHz);
    check("pp_fill", fl_m, 1);
    check("pp_data", do_m, 8'h22);
    step();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;

    // Async reset mid-word with two stored words
    send_word(8'h33);
    send_word(8'h44);
    strobe(1, 0); strobe(1, 0); strobe(1, 0); strobe(1, 0); strobe(1, 0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_ready",  dr_m, 0);
    check("arst_fill",   fl_m, 0);
    check("arst_status", st_m, 1);
    check("arst_ovf",    ov_m, 0);
    step();
    step();
    reset = 1'b1;
    step();
    send_word(8'hAD);
    @(negedge clk_100KHz);
    check("post_rst_msb",  do_m, 8'hAD);
    check("post_rst_fill", fl_m, 1);
    check("post_rst_lsb",  do_l, 8'hB5);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
